// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard unit.
// Register/opcode widths, load opcodes, scoreboard width, FSM states.
package hazard_pkg;

    localparam int NREG  = 32;
    localparam int REG_W = 5;
    localparam int OPC_W = 6;
    localparam int CNT_W = 2;
    localparam int HC_W  = 16;

    localparam logic [OPC_W-1:0] LW_OPC = 6'b100011;
    localparam logic [OPC_W-1:0] SW_OPC = 6'b101011;

    typedef enum logic {
        HZ_RUN,
        HZ_STALL
    } hz_state_t;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard cell: 2-bit countdown until a load result is forwardable.
// Priority: reset > flush > set > clear > decrement.
module sb_counter
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             set,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clr,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (set) begin
            cnt_q <= load_val;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detection: per-register load countdown scoreboard,
// ID-stage stall/bubble generation and a saturating stall-event counter.
module load_use_hazard_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 2
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_rd,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             stall,
    output logic             bubble,
    output logic [NREG-1:0]  pending_mask,
    output logic [HC_W-1:0]  hazard_count
);

    localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(LOAD_LAT);

    logic [NREG-1:0] busy;
    logic            issue;
    logic            ld_issue;
    logic            wb_hit;
    logic            pend_rs;
    logic            pend_rt;
    hz_state_t       state_q;
    logic [HC_W-1:0] count_q;

    assign busy[0] = 1'b0;

    genvar i;
    generate
        for (i = 1; i < NREG; i++) begin : g_cell
            logic set_i;
            logic clr_i;
            assign set_i = ld_issue && (id_rd == REG_W'(i));
            assign clr_i = wb_hit && (wb_rd == REG_W'(i));
            sb_counter u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .set      (set_i),
                .load_val (LAT_VAL),
                .clr      (clr_i),
                .busy     (busy[i])
            );
        end
    endgenerate

    // busy[0] is tied low, so reg 0 never reads as pending
    assign pend_rs = busy[id_rs];
    assign pend_rt = id_uses_rt && busy[id_rt];

    assign stall  = id_valid && !flush && (pend_rs || pend_rt);
    assign bubble = stall;

    assign issue    = id_valid && !stall && !flush;
    assign ld_issue = issue && id_wr_en && (id_rd != '0)
                      && (id_opcode == LW_OPC);
    assign wb_hit   = wb_valid && (wb_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
            count_q <= '0;
        end else if (flush) begin
            state_q <= HZ_RUN;
        end else begin
            unique case (state_q)
                HZ_RUN: begin
                    if (stall) begin
                        state_q <= HZ_STALL;
                        if (count_q != {HC_W{1'b1}})
                            count_q <= count_q + HC_W'(1);
                    end
                end
                HZ_STALL: begin
                    if (!stall)
                        state_q <= HZ_RUN;
                end
            endcase
        end
    end

    assign pending_mask = busy;
    assign hazard_count = count_q;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Self-checking bench: directed scenarios plus randomized run vs. model.
module tb_load_use_hazard_unit;
    import hazard_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [5:0]  id_opcode;
    logic        id_wr_en;
    logic [4:0]  id_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall;
    logic        bubble;
    logic [31:0] pending_mask;
    logic [15:0] hazard_count;

    int checks = 0;
    int errors = 0;

    load_use_hazard_unit #(.LOAD_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_opcode    (id_opcode),
        .id_wr_en     (id_wr_en),
        .id_rd        (id_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .stall        (stall),
        .bubble       (bubble),
        .pending_mask (pending_mask),
        .hazard_count (hazard_count)
    );

    always #5 clk = ~clk;

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        flush      = 1'b0;
        id_valid   = 1'b0;
        id_rs      = '0;
        id_rt      = '0;
        id_uses_rt = 1'b0;
        id_opcode  = '0;
        id_wr_en   = 1'b0;
        id_rd      = '0;
        wb_valid   = 1'b0;
        wb_rd      = '0;
    endtask

    task automatic set_lw(input logic [4:0] rd);
        idle();
        id_valid  = 1'b1;
        id_opcode = LW_OPC;
        id_wr_en  = 1'b1;
        id_rd     = rd;
    endtask

    task automatic set_read(input logic [4:0] rs, input logic [4:0] rt,
                            input logic use_rt);
        idle();
        id_valid   = 1'b1;
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rt = use_rt;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        adv();
        adv();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_lw(5'd8);
        adv();
        set_read(5'd8, 5'd0, 1'b0);
        settle();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_stall: stall=%b expected 1", stall);
        end
        adv();
        rst_n = 1'b0;
        repeat (3) adv();
        checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: stall=%b bubble=%b expected 0", stall, bubble);
        end
        checks++;
        if (pending_mask !== 32'h0) begin
            errors++;
            $display("FAIL reset_mask: got %h expected 0", pending_mask);
        end
        checks++;
        if (hazard_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_count: got %h expected 0", hazard_count);
        end
        checks++;
        if (dut.state_q !== HZ_RUN) begin
            errors++;
            $display("FAIL reset_fsm: got %0d expected RUN", dut.state_q);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_lw(5'd8);
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_issue: stall=%b expected 0", stall);
        end
        adv();
        set_read(5'd8, 5'd0, 1'b0);
        for (int c = 0; c < LAT; c++) begin
            settle();
            checks++;
            if (stall !== 1'b1 || bubble !== 1'b1 || pending_mask[8] !== 1'b1) begin
                errors++;
                $display("FAIL lu_stall%0d: stall=%b bubble=%b pend8=%b expected 1 1 1",
                         c, stall, bubble, pending_mask[8]);
            end
            adv();
        end
        checks++;
        if (stall !== 1'b0 || pending_mask !== 32'h0) begin
            errors++;
            $display("FAIL lu_release: stall=%b mask=%h expected 0 0", stall, pending_mask);
        end
        checks++;
        if (hazard_count !== 16'd1) begin
            errors++;
            $display("FAIL lu_count: got %0d expected 1", hazard_count);
        end
    endtask

    task automatic test_non_load();
        do_reset();
        idle();
        id_valid  = 1'b1;
        id_opcode = 6'b000000;
        id_wr_en  = 1'b1;
        id_rd     = 5'd8;
        adv();
        set_read(5'd8, 5'd0, 1'b0);
        settle();
        checks++;
        if (stall !== 1'b0 || pending_mask[8] !== 1'b0) begin
            errors++;
            $display("FAIL non_load: stall=%b pend8=%b expected 0 0", stall, pending_mask[8]);
        end
    endtask

    task automatic test_reg0();
        do_reset();
        set_lw(5'd0);
        adv();
        set_read(5'd0, 5'd0, 1'b1);
        settle();
        checks++;
        if (stall !== 1'b0 || pending_mask !== 32'h0) begin
            errors++;
            $display("FAIL reg0: stall=%b mask=%h expected 0 0", stall, pending_mask);
        end
    endtask

    task automatic test_uses_rt();
        do_reset();
        set_lw(5'd9);
        adv();
        set_read(5'd0, 5'd9, 1'b0);
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL rt_unused: stall=%b expected 0", stall);
        end
        do_reset();
        set_lw(5'd9);
        adv();
        set_read(5'd0, 5'd9, 1'b1);
        for (int c = 0; c < LAT; c++) begin
            settle();
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL rt_stall%0d: stall=%b expected 1", c, stall);
            end
            adv();
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL rt_release: stall=%b expected 0", stall);
        end
    endtask

    task automatic test_flush_wb();
        do_reset();
        set_lw(5'd5);
        adv();
        set_read(5'd5, 5'd0, 1'b0);
        flush = 1'b1;
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: stall=%b expected 0", stall);
        end
        adv();
        set_read(5'd5, 5'd0, 1'b0);
        settle();
        checks++;
        if (pending_mask !== 32'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: mask=%h stall=%b expected 0 0", pending_mask, stall);
        end
        // wb clear at countdown 1 and at countdown 2
        for (int w = 0; w < 2; w++) begin
            do_reset();
            set_lw(5'd5);
            adv();
            idle();
            if (w == 0) adv();
            wb_valid = 1'b1;
            wb_rd    = 5'd5;
            adv();
            idle();
            settle();
            checks++;
            if (pending_mask[5] !== 1'b0) begin
                errors++;
                $display("FAIL wb_clear%0d: pend5=%b expected 0", w, pending_mask[5]);
            end
        end
        // issue-set beats wb-clear on the same register
        do_reset();
        set_lw(5'd6);
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        adv();
        idle();
        settle();
        checks++;
        if (pending_mask[6] !== 1'b1) begin
            errors++;
            $display("FAIL set_over_wb: pend6=%b expected 1", pending_mask[6]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        set_lw(5'd3);
        adv();
        set_read(5'd3, 5'd0, 1'b0);
        adv();
        idle();
        settle();
        checks++;
        if (hazard_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate: got %h expected ffff", hazard_count);
        end
    endtask

    task automatic test_random();
        int  mcnt [32];
        bit  m_in_stall;
        int  mcount;
        bit  exp_stall;
        logic [31:0] exp_mask;
        bit  is_issue;
        do_reset();
        foreach (mcnt[k]) mcnt[k] = 0;
        m_in_stall = 1'b0;
        mcount = 0;
        for (int n = 0; n < 600; n++) begin
            idle();
            rst_n      = ($urandom_range(0, 59) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs      = 5'($urandom_range(0, 7));
            id_rt      = 5'($urandom_range(0, 7));
            id_uses_rt = 1'($urandom_range(0, 1));
            id_opcode  = ($urandom_range(0, 1) == 1) ? LW_OPC : 6'($urandom_range(0, 63));
            id_wr_en   = 1'($urandom_range(0, 1));
            id_rd      = 5'($urandom_range(0, 7));
            wb_valid   = ($urandom_range(0, 3) == 0);
            wb_rd      = 5'($urandom_range(0, 7));
            settle();
            exp_stall = id_valid && !flush &&
                        ((id_rs != 0 && mcnt[id_rs] > 0) ||
                         (id_uses_rt && id_rt != 0 && mcnt[id_rt] > 0));
            exp_mask = '0;
            for (int r = 1; r < 32; r++) exp_mask[r] = (mcnt[r] > 0);
            checks++;
            if (stall !== exp_stall || bubble !== exp_stall) begin
                errors++;
                $display("FAIL rnd_stall[%0d]: stall=%b bubble=%b expected %b",
                         n, stall, bubble, exp_stall);
            end
            checks++;
            if (pending_mask !== exp_mask) begin
                errors++;
                $display("FAIL rnd_mask[%0d]: got %h expected %h", n, pending_mask, exp_mask);
            end
            checks++;
            if (hazard_count !== 16'(mcount)) begin
                errors++;
                $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, hazard_count, mcount);
            end
            adv();
            if (!rst_n) begin
                foreach (mcnt[k]) mcnt[k] = 0;
                m_in_stall = 1'b0;
                mcount = 0;
            end else if (flush) begin
                foreach (mcnt[k]) mcnt[k] = 0;
                m_in_stall = 1'b0;
            end else begin
                is_issue = id_valid && !exp_stall;
                for (int r = 1; r < 32; r++) begin
                    if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
                    if (wb_valid && wb_rd == r) mcnt[r] = 0;
                    if (is_issue && id_wr_en && id_opcode == LW_OPC && id_rd == r)
                        mcnt[r] = LAT;
                end
                if (exp_stall && !m_in_stall && mcount < 65535) mcount++;
                m_in_stall = exp_stall;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        adv();
        test_reset();
        test_load_use();
        test_non_load();
        test_reg0();
        test_uses_rt();
        test_flush_wb();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
